// File: rtl/tri_pkg.sv
// tri_pkg: shared constants for the ternary memory path.
//   TRYTE_W     : width of one tryte word (18 bits).
//   PT_X/PT_R/PT_W : RAM access-type encodings (m_pt, 2-bit signed).
//   arb_state_e : trimem_arb FSM states.
package tri_pkg;

  localparam int unsigned TRYTE_W = 18;

  localparam logic signed [1:0] PT_W = 2'b00;
  localparam logic signed [1:0] PT_R = 2'b01;
  localparam logic signed [1:0] PT_X = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_INV  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/trimem_sreg_watch.sv
// trimem_sreg_watch: registers the MMU special registers every cycle and
// flags a difference between the live value and the registered copy.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   pgtn, psw, pgtp     : special registers (TRYTE_W each)
//   changed             : high for the one cycle in which any bit differs
//                         from the previous cycle's value
module trimem_sreg_watch
  import tri_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [TRYTE_W-1:0] pgtn,
  input  logic [TRYTE_W-1:0] psw,
  input  logic [TRYTE_W-1:0] pgtp,
  output logic               changed
);

  logic [3*TRYTE_W-1:0] cur;
  logic [3*TRYTE_W-1:0] prev;

  assign cur     = {pgtn, psw, pgtp};
  assign changed = (cur != prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
    end else begin
      prev <= cur;
    end
  end

endmodule

// File: rtl/trimem_arb.sv
// trimem_arb: merges the fetch (X) and load/store (R/W) requesters onto the
// ternary RAM/MMU single-cycle enable handshake, routes the response back to
// the issuing requester, and sequences the MMU-cache invalidate pulse.
// Parameters:
//   TIMEOUT_CYC : BUSY cycles without m_o before forcing a pagefault ack.
// Config macro:
//   TRIMEM_ARB_RR_EN : round-robin arbitration (default: load/store wins).
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   pgtn, psw, pgtp                    : special registers, watched for change
//   inv_req                            : software invalidate request pulse
//   if_req/if_addr -> if_ack/if_pf/if_data : fetch requester
//   ls_req/ls_write/ls_addr/ls_in -> ls_ack/ls_pf/ls_data : load/store
//   m_e/m_write/m_pt/m_addr/m_in       : RAM request (m_e one-cycle)
//   m_o/m_pf/m_out                     : RAM response
//   m_inv                              : RAM invalidate_cache pulse
module trimem_arb
  import tri_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [TRYTE_W-1:0] pgtn,
  input  logic [TRYTE_W-1:0] psw,
  input  logic [TRYTE_W-1:0] pgtp,
  input  logic               inv_req,
  input  logic               if_req,
  input  logic [TRYTE_W-1:0] if_addr,
  output logic               if_ack,
  output logic               if_pf,
  output logic [TRYTE_W-1:0] if_data,
  input  logic               ls_req,
  input  logic               ls_write,
  input  logic [TRYTE_W-1:0] ls_addr,
  input  logic [TRYTE_W-1:0] ls_in,
  output logic               ls_ack,
  output logic               ls_pf,
  output logic [TRYTE_W-1:0] ls_data,
  output logic               m_e,
  output logic               m_write,
  output logic signed [1:0]  m_pt,
  output logic [TRYTE_W-1:0] m_addr,
  output logic [TRYTE_W-1:0] m_in,
  input  logic               m_o,
  input  logic               m_pf,
  input  logic [TRYTE_W-1:0] m_out,
  output logic               m_inv
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  arb_state_e    state, state_n;
  logic          inv_pend;
  logic          changed;
  logic          own;        // 0 = fetch, 1 = load/store
  logic [CW-1:0] cnt;

  logic if_p, ls_p, any_p, grant_ls;
  logic issue, done, done_pf, load_data, clr_inv;

  trimem_sreg_watch u_watch (
    .clk     (clk),
    .rst_n   (rst_n),
    .pgtn    (pgtn),
    .psw     (psw),
    .pgtp    (pgtp),
    .changed (changed)
  );

  // A requester still sees its own ack cycle with req high; mask it so the
  // arbiter does not re-grant a request that is just being completed.
  assign if_p  = if_req & ~if_ack;
  assign ls_p  = ls_req & ~ls_ack;
  assign any_p = if_p | ls_p;

`ifdef TRIMEM_ARB_RR_EN
  logic last_ls;

  assign grant_ls = ls_p & (~if_p | ~last_ls);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ls <= 1'b1;
    end else if (issue) begin
      last_ls <= grant_ls;
    end
  end
`else
  assign grant_ls = ls_p;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    issue     = 1'b0;
    done      = 1'b0;
    done_pf   = 1'b0;
    load_data = 1'b0;
    clr_inv   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (inv_pend) begin
          state_n = ST_INV;
        end else if (any_p) begin
          issue   = 1'b1;
          state_n = ST_BUSY;
        end
      end
      ST_INV: begin
        // The flush cycle also takes the grant decision, so a pending
        // invalidate costs one cycle; a fresh change sends us back to IDLE
        // so it is flushed before any access.
        clr_inv = 1'b1;
        if (!(changed || inv_req) && any_p) begin
          issue   = 1'b1;
          state_n = ST_BUSY;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (m_o) begin
          done      = 1'b1;
          done_pf   = m_pf;
          load_data = ~m_pf;
          state_n   = ST_IDLE;
        end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          done    = 1'b1;
          done_pf = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_pend <= 1'b1;
      own      <= 1'b0;
      cnt      <= '0;
      m_e      <= 1'b0;
      m_write  <= 1'b0;
      m_pt     <= PT_W;
      m_addr   <= '0;
      m_in     <= '0;
      m_inv    <= 1'b0;
      if_ack   <= 1'b0;
      if_pf    <= 1'b0;
      if_data  <= '0;
      ls_ack   <= 1'b0;
      ls_pf    <= 1'b0;
      ls_data  <= '0;
    end else begin
      inv_pend <= (inv_pend & ~clr_inv) | changed | inv_req;
      m_e      <= issue;
      m_inv    <= (state_n == ST_INV);
      if_ack   <= done & ~own;
      ls_ack   <= done & own;

      if (issue) begin
        own     <= grant_ls;
        cnt     <= '0;
        m_write <= grant_ls & ls_write;
        m_pt    <= grant_ls ? (ls_write ? PT_W : PT_R) : PT_X;
        m_addr  <= grant_ls ? ls_addr : if_addr;
        m_in    <= grant_ls ? ls_in : '0;
      end else if (state == ST_BUSY) begin
        cnt <= cnt + CW'(1);
      end

      if (done && !own) begin
        if_pf <= done_pf;
        if (load_data) begin
          if_data <= m_out;
        end
      end
      if (done && own) begin
        ls_pf <= done_pf;
        if (load_data) begin
          ls_data <= m_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_trimem_arb.sv
`timescale 1ns/1ps
module tb_trimem_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] pgtn, psw, pgtp;
  logic        inv_req;
  logic        if_req;
  logic [17:0] if_addr;
  logic        if_ack, if_pf;
  logic [17:0] if_data;
  logic        ls_req, ls_write;
  logic [17:0] ls_addr, ls_in;
  logic        ls_ack, ls_pf;
  logic [17:0] ls_data;
  logic        m_e, m_write;
  logic signed [1:0] m_pt;
  logic [17:0] m_addr, m_in;
  logic        m_o, m_pf;
  logic [17:0] m_out;
  logic        m_inv;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // RAM model knobs: ram_lat = cycles from m_e to m_o (0 = never answers)
  int          ram_lat  = 1;
  int          ram_pend = 0;
  logic        ram_pf   = 1'b0;
  logic [17:0] ram_data = '0;

`ifdef TRIMEM_ARB_RR_EN
  logic rr_last_ls = 1'b1;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  trimem_arb #(.TIMEOUT_CYC(15)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pgtn     (pgtn),
    .psw      (psw),
    .pgtp     (pgtp),
    .inv_req  (inv_req),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_pf    (if_pf),
    .if_data  (if_data),
    .ls_req   (ls_req),
    .ls_write (ls_write),
    .ls_addr  (ls_addr),
    .ls_in    (ls_in),
    .ls_ack   (ls_ack),
    .ls_pf    (ls_pf),
    .ls_data  (ls_data),
    .m_e      (m_e),
    .m_write  (m_write),
    .m_pt     (m_pt),
    .m_addr   (m_addr),
    .m_in     (m_in),
    .m_o      (m_o),
    .m_pf     (m_pf),
    .m_out    (m_out),
    .m_inv    (m_inv)
  );

  initial begin
    m_o   = 1'b0;
    m_pf  = 1'b0;
    m_out = '0;
    forever begin
      @(posedge clk);
      #1;
      m_o  = 1'b0;
      m_pf = 1'b0;
      if (ram_pend > 0) begin
        ram_pend--;
        if (ram_pend == 0) begin
          m_o   = 1'b1;
          m_pf  = ram_pf;
          m_out = ram_data;
        end
      end
      if (m_e) ram_pend = ram_lat;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  function automatic logic [80:0] outs();
    return {if_ack, if_pf, if_data, ls_ack, ls_pf, ls_data,
            m_e, m_write, m_pt, m_addr, m_in, m_inv};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n_inv;
    logic first_inv, first_me;
    rst_n = 1'b0; pgtn = '0; psw = '0; pgtp = '0; inv_req = 1'b0;
    if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_write = 1'b0;
    ls_addr = '0; ls_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (outs() !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0", outs());
    end
    rst_n = 1'b1;
    @(negedge clk);
    first_inv = m_inv;
    first_me  = m_e;
    tests++;
    if (first_inv !== 1'b1) begin
      fails++; $display("FAIL reset_flush_inv: got %b expected 1", first_inv);
    end
    tests++;
    if (first_me !== 1'b0) begin
      fails++; $display("FAIL reset_flush_no_me: got %b expected 0", first_me);
    end
    n_inv = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (m_inv) n_inv++;
    end
    tests++;
    if (n_inv != 1) begin
      fails++; $display("FAIL reset_inv_count: got %0d expected 1", n_inv);
    end
  endtask

  task automatic test_fetch();
    int t0, t_ack, n_me;
    logic [1:0]  pt;
    logic [17:0] addr, d;
    logic        pf;
    ram_lat = 1; ram_pf = 1'b0; ram_data = 18'h15555;
    tick();
    if_addr = 18'h00155; if_req = 1'b1; t0 = cyc;
    t_ack = -1; n_me = 0; pt = '0; addr = '0; d = '0; pf = 1'bx;
    for (int i = 0; i < 20 && t_ack < 0; i++) begin
      @(negedge clk);
      if (m_e) begin n_me++; pt = m_pt; addr = m_addr; end
      if (if_ack) begin t_ack = cyc; d = if_data; pf = if_pf; if_req = 1'b0; end
    end
    if_req = 1'b0;
`ifdef TRIMEM_ARB_RR_EN
    rr_last_ls = 1'b0;
`endif
    tests++;
    if (t_ack - t0 != 3) begin
      fails++; $display("FAIL fetch_latency: got %0d expected 3", t_ack - t0);
    end
    tests++;
    if (pt !== 2'b11) begin
      fails++; $display("FAIL fetch_pt: got %b expected 11", pt);
    end
    tests++;
    if (addr !== 18'h00155) begin
      fails++; $display("FAIL fetch_addr: got %h expected 00155", addr);
    end
    tests++;
    if (d !== 18'h15555) begin
      fails++; $display("FAIL fetch_data: got %h expected 15555", d);
    end
    tests++;
    if (pf !== 1'b0) begin
      fails++; $display("FAIL fetch_pf: got %b expected 0", pf);
    end
    tests++;
    if (n_me != 1) begin
      fails++; $display("FAIL fetch_me_count: got %0d expected 1", n_me);
    end
  endtask

  task automatic test_priority();
    logic [1:0]  g_pt [2];
    logic [17:0] g_in [2];
    logic        g_wr [2];
    int          g_t  [2];
    int          ng, ls_idx;
    logic        if_done, ls_done, exp_ls_first;
    logic [1:0]  exp_pt0, exp_pt1;
    ram_lat = 1; ram_pf = 1'b0; ram_data = 18'h00aaa;
    for (int pair = 0; pair < 2; pair++) begin
`ifdef TRIMEM_ARB_RR_EN
      exp_ls_first = ~rr_last_ls;
`else
      exp_ls_first = 1'b1;
`endif
      exp_pt0 = exp_ls_first ? 2'b00 : 2'b11;
      exp_pt1 = exp_ls_first ? 2'b11 : 2'b00;
      ls_idx  = exp_ls_first ? 0 : 1;
      tick();
      if_addr = 18'h00020; if_req = 1'b1;
      ls_write = 1'b1; ls_addr = 18'h00200; ls_in = 18'h00001; ls_req = 1'b1;
      ng = 0; if_done = 1'b0; ls_done = 1'b0;
      for (int k = 0; k < 2; k++) begin g_pt[k] = 'x; g_in[k] = 'x; g_wr[k] = 1'bx; g_t[k] = -100; end
      for (int i = 0; i < 30 && !(if_done && ls_done); i++) begin
        @(negedge clk);
        if (m_e && ng < 2) begin
          g_pt[ng] = m_pt; g_in[ng] = m_in; g_wr[ng] = m_write; g_t[ng] = cyc; ng++;
        end
        if (if_ack) begin if_done = 1'b1; if_req = 1'b0; end
        if (ls_ack) begin ls_done = 1'b1; ls_req = 1'b0; end
      end
      if_req = 1'b0; ls_req = 1'b0;
`ifdef TRIMEM_ARB_RR_EN
      rr_last_ls = ~exp_ls_first;
`endif
      tests++;
      if (!(if_done && ls_done && ng == 2)) begin
        fails++; $display("FAIL prio_complete[%0d]: got acks if=%b ls=%b grants=%0d expected 1 1 2",
                          pair, if_done, ls_done, ng);
      end
      tests++;
      if (g_pt[0] !== exp_pt0) begin
        fails++; $display("FAIL prio_first_pt[%0d]: got %b expected %b", pair, g_pt[0], exp_pt0);
      end
      tests++;
      if (g_pt[1] !== exp_pt1) begin
        fails++; $display("FAIL prio_second_pt[%0d]: got %b expected %b", pair, g_pt[1], exp_pt1);
      end
      tests++;
      if (g_t[1] - g_t[0] != 3) begin
        fails++; $display("FAIL prio_spacing[%0d]: got %0d expected 3", pair, g_t[1] - g_t[0]);
      end
      tests++;
      if ({g_wr[ls_idx], g_in[ls_idx]} !== {1'b1, 18'h00001}) begin
        fails++; $display("FAIL prio_store_fields[%0d]: got wr=%b in=%h expected wr=1 in=00001",
                          pair, g_wr[ls_idx], g_in[ls_idx]);
      end
    end
  endtask

  task automatic test_inv_busy();
    int tA, t_ack, t_inv, t_me2, n_inv;
    logic [1:0]  pt2;
    logic [17:0] d, ld;
    logic        pf, ls_done;
    ram_lat = 2; ram_pf = 1'b0; ram_data = 18'h00777;
    tick();
    if_addr = 18'h00010; if_req = 1'b1;
    tA = -1; t_ack = -1; t_inv = -1; t_me2 = -1; n_inv = 0;
    pt2 = 'x; d = 'x; ld = 'x; pf = 1'bx; ls_done = 1'b0;
    for (int i = 0; i < 40 && !ls_done; i++) begin
      @(negedge clk);
      if (m_inv) begin n_inv++; if (t_inv < 0) t_inv = cyc; end
      if (m_e) begin
        if (tA < 0) begin tA = cyc; psw = 18'h00005; end
        else if (t_me2 < 0) begin t_me2 = cyc; pt2 = m_pt; end
      end
      if (if_ack) begin
        t_ack = cyc; d = if_data; pf = if_pf; if_req = 1'b0;
        ls_write = 1'b0; ls_addr = 18'h00300; ls_req = 1'b1;
      end
      if (ls_ack) begin ls_done = 1'b1; ld = ls_data; ls_req = 1'b0; end
    end
    if_req = 1'b0; ls_req = 1'b0;
`ifdef TRIMEM_ARB_RR_EN
    rr_last_ls = 1'b1;
`endif
    tests++;
    if (tA < 0 || t_ack != tA + 3) begin
      fails++; $display("FAIL walk_ack_time: got %0d expected %0d", t_ack, tA + 3);
    end
    tests++;
    if ({pf, d} !== {1'b0, 18'h00777}) begin
      fails++; $display("FAIL walk_ack_data: got pf=%b data=%h expected pf=0 data=00777", pf, d);
    end
    tests++;
    if (tA < 0 || t_inv != tA + 4) begin
      fails++; $display("FAIL walk_inv_time: got %0d expected %0d", t_inv, tA + 4);
    end
    tests++;
    if (n_inv != 1) begin
      fails++; $display("FAIL walk_inv_count: got %0d expected 1", n_inv);
    end
    tests++;
    if (tA < 0 || t_me2 != tA + 5) begin
      fails++; $display("FAIL walk_next_issue: got %0d expected %0d", t_me2, tA + 5);
    end
    tests++;
    if (pt2 !== 2'b01) begin
      fails++; $display("FAIL walk_load_pt: got %b expected 01", pt2);
    end
    tests++;
    if (!ls_done || ld !== 18'h00777) begin
      fails++; $display("FAIL walk_load_data: got done=%b data=%h expected done=1 data=00777", ls_done, ld);
    end
  endtask

  task automatic test_pagefault();
    int t0, t_ack, n_if;
    logic [17:0] d;
    logic        pf;
    ram_lat = 1; ram_pf = 1'b1; ram_data = 18'h3ffff;
    tick();
    ls_write = 1'b0; ls_addr = 18'h00301; ls_req = 1'b1; t0 = cyc;
    t_ack = -1; n_if = 0; d = 'x; pf = 1'bx;
    for (int i = 0; i < 20 && t_ack < 0; i++) begin
      @(negedge clk);
      if (if_ack) n_if++;
      if (ls_ack) begin t_ack = cyc; d = ls_data; pf = ls_pf; ls_req = 1'b0; end
    end
    ls_req = 1'b0;
    tests++;
    if (t_ack - t0 != 3) begin
      fails++; $display("FAIL pf_latency: got %0d expected 3", t_ack - t0);
    end
    tests++;
    if (pf !== 1'b1) begin
      fails++; $display("FAIL pf_flag: got %b expected 1", pf);
    end
    tests++;
    if (d !== 18'h00777) begin
      fails++; $display("FAIL pf_data_hold: got %h expected 00777", d);
    end
    tests++;
    if (n_if != 0) begin
      fails++; $display("FAIL pf_wrong_ack: got %0d fetch acks expected 0", n_if);
    end
  endtask

  task automatic test_timeout();
    int t0, t_ack, n_ack, t_me;
    logic [17:0] d;
    logic        pf;
    ram_lat = 0; ram_pf = 1'b0;
    tick();
    if_addr = 18'h00040; if_req = 1'b1; t0 = cyc;
    t_ack = -1; d = 'x; pf = 1'bx;
    for (int i = 0; i < 30 && t_ack < 0; i++) begin
      @(negedge clk);
      if (if_ack) begin t_ack = cyc; d = if_data; pf = if_pf; if_req = 1'b0; end
    end
    if_req = 1'b0;
    tests++;
    if (t_ack - t0 != 16) begin
      fails++; $display("FAIL timeout_latency: got %0d expected 16", t_ack - t0);
    end
    tests++;
    if (pf !== 1'b1) begin
      fails++; $display("FAIL timeout_pf: got %b expected 1", pf);
    end
    tests++;
    if (d !== 18'h00777) begin
      fails++; $display("FAIL timeout_data_hold: got %h expected 00777", d);
    end

    // Second run: reset in the middle of BUSY drops the access.
    tick();
    if_addr = 18'h00041; if_req = 1'b1;
    t_me = -1; n_ack = 0;
    for (int i = 0; i < 10 && t_me < 0; i++) begin
      @(negedge clk);
      if (m_e) t_me = cyc;
    end
    repeat (3) begin
      @(negedge clk);
      if (if_ack) n_ack++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (t_me < 0 || outs() !== '0) begin
      fails++; $display("FAIL midbusy_reset_outputs: got %h (issue seen %0d) expected 0", outs(), t_me);
    end
    if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (if_ack) n_ack++;
    end
    tests++;
    if (n_ack != 0) begin
      fails++; $display("FAIL midbusy_reset_ack: got %0d acks expected 0", n_ack);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_inv_busy();
    test_pagefault();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
